mem_bus_arbiter: RTL

//  Shares the single-port system memory (memoryMap) between the 6502C CPU and one DMA

---
 rtl/mem_bus_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares the single-port system memory between the 6502C CPU and one
//   read-only DMA requester (display fetch). A DMA request halts the CPU via
//   an active-low HALT. Grants only happen after a CPU read cycle, because the
//   CPU cannot be stalled in the middle of a write. The DMA requester then gets
//   bounded read bursts, and the CPU gets at least one cycle between bursts.
//   One memory access is made per rising edge of the bus-cycle clock.
//
// Ports
//   i_clk         bus-cycle clock
//   i_rst         asynchronous, active-high reset
//   i_cpu_addr    CPU address
//   i_cpu_rw      1 = CPU read, 0 = CPU write
//   i_cpu_wdata   CPU write data
//   o_cpu_rdata   read data returned to the CPU
//   o_cpu_halt_l  0 = CPU stalled
//   i_dma_req     DMA request, held high while more fetches are wanted
//   i_dma_addr    DMA fetch address
//   o_dma_grant   1 = current cycle is a DMA read cycle
//   o_dma_ack     one-cycle pulse: o_dma_rdata valid
//   o_dma_rdata   DMA read data
//   o_mem_addr    memory address
//   o_mem_we      memory write enable
//   o_mem_wdata   memory write data
//   i_mem_rdata   memory read data, valid the cycle after o_mem_addr
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic              i_cpu_rw,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_halt_l,
  input  logic              i_dma_req,
  input  logic [ADDR_W-1:0] i_dma_addr,
  output logic              o_dma_grant,
  output logic              o_dma_ack,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    ST_CPU       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_DMA       = 2'd2,
    ST_RELEASE   = 2'd3
  } state_t;

  localparam logic [7:0] LP_MAX_BURST = 8'(MAX_BURST);

  state_t            r_state;
  logic [7:0]        r_burst_cnt;
  // Owner of the read issued in the previous cycle (one flag per owner).
  logic              r_cpu_rd_q;
  logic              r_dma_rd_q;
  // Last returned data, held between reads.
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  logic              w_dma_owner;
  logic              w_dma_grant;
  logic              w_cpu_read;
  logic [7:0]        w_burst_inc;

  assign w_dma_owner = (r_state == ST_DMA);
  // With the request dropped, the DMA state still owns the bus but makes no access.
  assign w_dma_grant = w_dma_owner & i_dma_req;
  assign w_cpu_read  = ~w_dma_owner & i_cpu_rw;
  assign w_burst_inc = r_burst_cnt + 8'd1;

  // Bus steering
  assign o_mem_addr   = w_dma_owner ? i_dma_addr : i_cpu_addr;
  assign o_mem_wdata  = i_cpu_wdata;
  // Reset forces the write strobe low immediately, even while a CPU write is presented.
  assign o_mem_we     = ~i_rst & ~w_dma_owner & ~i_cpu_rw;

  assign o_cpu_halt_l = ~((r_state == ST_HALT_PEND) || (r_state == ST_DMA));
  assign o_dma_grant  = w_dma_grant;
  assign o_dma_ack    = r_dma_rd_q;

  // Synchronous RAM data arrives in the cycle after the address; it is passed
  // straight through in that cycle and captured so it holds afterwards.
  assign o_cpu_rdata  = r_cpu_rd_q ? i_mem_rdata : r_cpu_rdata;
  assign o_dma_rdata  = r_dma_rd_q ? i_mem_rdata : r_dma_rdata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_CPU;
      r_burst_cnt <= 8'd0;
      r_cpu_rd_q  <= 1'b0;
      r_dma_rd_q  <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_cpu_rd_q <= w_cpu_read;
      r_dma_rd_q <= w_dma_grant;
      if (r_cpu_rd_q) begin
        r_cpu_rdata <= i_mem_rdata;
      end
      if (r_dma_rd_q) begin
        r_dma_rdata <= i_mem_rdata;
      end

      case (r_state)
        ST_CPU: begin
          if (i_dma_req) begin
            r_state <= ST_HALT_PEND;
          end
        end
        ST_HALT_PEND: begin
          // HALT only takes effect on a CPU read; writes keep us waiting here.
          if (!i_dma_req) begin
            r_state <= ST_CPU;
          end else if (i_cpu_rw) begin
            r_state     <= ST_DMA;
            r_burst_cnt <= 8'd0;
          end
        end
        ST_DMA: begin
          if (!i_dma_req) begin
            r_state <= ST_RELEASE;
          end else begin
            r_burst_cnt <= w_burst_inc;
            if (w_burst_inc == LP_MAX_BURST) begin
              r_state <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          // A new request always passes through HALT_PEND so the CPU gets this cycle.
          r_state <= i_dma_req ? ST_HALT_PEND : ST_CPU;
        end
        default: begin
          r_state <= ST_CPU;
        end
      endcase
    end
  end

endmodule
